// File: rtl/hram_arb_pkg.sv
// Shared definitions for the HyperRAM data-port arbiter: FSM states, Wishbone
// cycle-type codes and a constant-safe ceil(log2) helper.
package hram_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN   = 2'd1,
        ST_ABORT = 2'd2
    } state_t;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;

    // Never returns less than 1 so that derived vectors always have a bit.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/wb_hram_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester found searching upward
// from last+1, wrapping modulo NUM_M (which need not be a power of two).
module rr_pick
    import hram_arb_pkg::*;
#(
    parameter int NUM_M = 3,
    parameter int PW    = clog2(NUM_M)
) (
    input  logic [NUM_M-1:0] req,
    input  logic [PW-1:0]    last,
    output logic [NUM_M-1:0] win,
    output logic [PW-1:0]    idx,
    output logic             any
);

    logic [PW-1:0] cand;
    logic          found;

    always_comb begin
        win   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 1; k <= NUM_M; k++) begin
            cand = PW'((int'(last) + k) % NUM_M);
            if (!found && req[cand]) begin
                found     = 1'b1;
                win[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/wb_hram_arbiter.sv
// Round-robin Wishbone arbiter sharing the HyperRAM data port between masters;
// a grant is held for the owner's whole cyc, with a no-ack watchdog abort.
module wb_hram_arbiter
    import hram_arb_pkg::*;
#(
    parameter int NUM_M   = 3,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 1023
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    input  logic [NUM_M-1:0]        m_cyc_i,
    input  logic [NUM_M-1:0]        m_stb_i,
    input  logic [NUM_M-1:0]        m_we_i,
    input  logic [NUM_M*AW-1:0]     m_adr_i,
    input  logic [NUM_M*DW-1:0]     m_dat_i,
    input  logic [NUM_M*(DW/8)-1:0] m_sel_i,
    input  logic [NUM_M*3-1:0]      m_cti_i,
    output logic [DW-1:0]           m_dat_o,
    output logic [NUM_M-1:0]        m_ack_o,
    output logic [NUM_M-1:0]        m_err_o,
    output logic                    s_cyc_o,
    output logic                    s_stb_o,
    output logic                    s_we_o,
    output logic [AW-1:0]           s_adr_o,
    output logic [DW-1:0]           s_dat_o,
    output logic [DW/8-1:0]         s_sel_o,
    output logic [2:0]              s_cti_o,
    input  logic [DW-1:0]           s_dat_i,
    input  logic                    s_ack_i,
    output logic [NUM_M-1:0]        grant_o,
    output logic                    timeout_o
);

    localparam int PW = clog2(NUM_M);
    localparam int WW = clog2(TIMEOUT + 1);
    localparam int SW = DW / 8;

    state_t           state, state_nxt;
    logic [NUM_M-1:0] grant_nxt;
    logic [PW-1:0]    gidx, gidx_nxt;
    logic [PW-1:0]    last, last_nxt;
    logic [WW-1:0]    wdog, wdog_nxt;
    logic             timeout_nxt;

    logic [NUM_M-1:0] win;
    logic [PW-1:0]    win_idx;
    logic             any_req;

    logic [AW-1:0]    adr_arr [NUM_M];
    logic [DW-1:0]    dat_arr [NUM_M];
    logic [SW-1:0]    sel_arr [NUM_M];
    logic [2:0]       cti_arr [NUM_M];

    logic             live;
    logic             stall;

    for (genvar i = 0; i < NUM_M; i++) begin : g_unpack
        assign adr_arr[i] = m_adr_i[i*AW +: AW];
        assign dat_arr[i] = m_dat_i[i*DW +: DW];
        assign sel_arr[i] = m_sel_i[i*SW +: SW];
        assign cti_arr[i] = m_cti_i[i*3 +: 3];
    end

    rr_pick #(
        .NUM_M (NUM_M),
        .PW    (PW)
    ) u_pick (
        .req  (m_cyc_i),
        .last (last),
        .win  (win),
        .idx  (win_idx),
        .any  (any_req)
    );

    // Everything towards the slave gates on the owner's live cyc, so a master
    // that drops cyc right as it is granted never produces a strobe or an ack.
    assign live  = (state == ST_OWN) && m_cyc_i[gidx];
    assign stall = s_stb_o && !s_ack_i;

    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        s_cti_o = '0;
        m_ack_o = '0;
        m_err_o = '0;
        m_dat_o = s_dat_i;
        if (live) begin
            s_cyc_o       = 1'b1;
            s_stb_o       = m_stb_i[gidx];
            s_we_o        = m_we_i[gidx];
            s_adr_o       = adr_arr[gidx];
            s_dat_o       = dat_arr[gidx];
            s_sel_o       = sel_arr[gidx];
            s_cti_o       = cti_arr[gidx];
            m_ack_o[gidx] = s_ack_i;
        end
        if (state == ST_ABORT) begin
            m_err_o[gidx] = 1'b1;
        end
    end

    always_comb begin
        state_nxt   = state;
        grant_nxt   = grant_o;
        gidx_nxt    = gidx;
        last_nxt    = last;
        wdog_nxt    = '0;
        timeout_nxt = timeout_o;
        case (state)
            ST_IDLE: begin
                if (any_req) begin
                    grant_nxt = win;
                    gidx_nxt  = win_idx;
                    last_nxt  = win_idx;
                    state_nxt = ST_OWN;
                end
            end
            ST_OWN: begin
                if (!m_cyc_i[gidx]) begin
                    grant_nxt = '0;
                    state_nxt = ST_IDLE;
                end else if (stall && TIMEOUT != 0) begin
                    if (wdog == WW'(TIMEOUT - 1)) begin
                        state_nxt = ST_ABORT;
                    end else begin
                        wdog_nxt = wdog + 1'b1;
                    end
                end
            end
            ST_ABORT: begin
                timeout_nxt = 1'b1;
                grant_nxt   = '0;
                state_nxt   = ST_IDLE;
            end
            default: begin
                grant_nxt = '0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Reset leaves last at NUM_M-1 so master 0 wins the first arbitration.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state     <= ST_IDLE;
            grant_o   <= '0;
            gidx      <= '0;
            last      <= PW'(NUM_M - 1);
            wdog      <= '0;
            timeout_o <= 1'b0;
        end else begin
            state     <= state_nxt;
            grant_o   <= grant_nxt;
            gidx      <= gidx_nxt;
            last      <= last_nxt;
            wdog      <= wdog_nxt;
            timeout_o <= timeout_nxt;
        end
    end

endmodule

// File: tb/tb_wb_hram_arbiter.sv
// Directed bench for wb_hram_arbiter with three masters and a 16-cycle watchdog.
module tb_wb_hram_arbiter;
    import hram_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  m_cyc, m_stb, m_we;
    logic [95:0] m_adr, m_dat;
    logic [11:0] m_sel;
    logic [8:0]  m_cti;
    logic [31:0] s_dat_i;
    logic        s_ack;

    logic [31:0] m_dat_o;
    logic [2:0]  m_ack, m_err, grant;
    logic        s_cyc, s_stb, s_we;
    logic [31:0] s_adr, s_dat_o;
    logic [3:0]  s_sel;
    logic [2:0]  s_cti;
    logic        timeout;

    int total;
    int bad;
    int order [4];
    int g;

    always #5 clk = ~clk;

    wb_hram_arbiter #(
        .NUM_M   (3),
        .AW      (32),
        .DW      (32),
        .TIMEOUT (16)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .m_cyc_i   (m_cyc),
        .m_stb_i   (m_stb),
        .m_we_i    (m_we),
        .m_adr_i   (m_adr),
        .m_dat_i   (m_dat),
        .m_sel_i   (m_sel),
        .m_cti_i   (m_cti),
        .m_dat_o   (m_dat_o),
        .m_ack_o   (m_ack),
        .m_err_o   (m_err),
        .s_cyc_o   (s_cyc),
        .s_stb_o   (s_stb),
        .s_we_o    (s_we),
        .s_adr_o   (s_adr),
        .s_dat_o   (s_dat_o),
        .s_sel_o   (s_sel),
        .s_cti_o   (s_cti),
        .s_dat_i   (s_dat_i),
        .s_ack_i   (s_ack),
        .grant_o   (grant),
        .timeout_o (timeout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic mset(input int i, input logic cyc, input logic we,
                        input logic [31:0] adr, input logic [2:0] cti);
        m_cyc[i]          = cyc;
        m_stb[i]          = cyc;
        m_we[i]           = we;
        m_adr[i*32 +: 32] = adr;
        m_dat[i*32 +: 32] = adr ^ 32'h5A5A_0000;
        m_sel[i*4 +: 4]   = 4'hF;
        m_cti[i*3 +: 3]   = cti;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        #1;
        check("rst_grant", {29'd0, grant}, 32'd0);
        check("rst_scyc", {31'd0, s_cyc}, 32'd0);
        check("rst_tmo", {31'd0, timeout}, 32'd0);
        tick;
        rst = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        m_cyc = '0; m_stb = '0; m_we = '0;
        m_adr = '0; m_dat = '0; m_sel = '0; m_cti = '0;
        s_ack = 1'b0; s_dat_i = '0;
        #1;
        check("rst_grant0", {29'd0, grant}, 32'd0);
        check("rst_ack0", {29'd0, m_ack}, 32'd0);
        tick;
        rst = 1'b0;
        tick;

        // single master 1, classic read, slave acks in the third cycle
        mset(1, 1'b1, 1'b0, 32'h100, CTI_CLASSIC);
        tick;
        check("t1_grant", {29'd0, grant}, 32'd2);
        check("t1_scyc", {31'd0, s_cyc}, 32'd1);
        check("t1_sstb", {31'd0, s_stb}, 32'd1);
        check("t1_adr", s_adr, 32'h100);
        check("t1_sel", {28'd0, s_sel}, 32'hF);
        check("t1_noack", {29'd0, m_ack}, 32'd0);
        tick;
        check("t1_noack2", {29'd0, m_ack}, 32'd0);
        tick;
        s_ack = 1'b1; s_dat_i = 32'hCAFE_0001;
        #1;
        check("t1_ack", {29'd0, m_ack}, 32'd2);
        check("t1_rdata", m_dat_o, 32'hCAFE_0001);
        tick;
        s_ack = 1'b0;
        mset(1, 1'b0, 1'b0, 32'h0, CTI_CLASSIC);
        #1;
        check("t1_ack_once", {29'd0, m_ack}, 32'd0);
        check("t1_cyc_drop", {31'd0, s_cyc}, 32'd0);
        tick;
        check("t1_idle", {29'd0, grant}, 32'd0);

        // contention from reset: grant order 0,1,2,0 with idle gaps
        do_reset;
        for (int i = 0; i < 3; i++) mset(i, 1'b1, 1'b0, 32'h1000 + i * 16, CTI_CLASSIC);
        order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 0;
        for (int k = 0; k < 4; k++) begin
            g = order[k];
            tick;
            check("rr_grant", {29'd0, grant}, 32'd1 << g);
            check("rr_adr", s_adr, 32'h1000 + g * 16);
            s_ack = 1'b1; s_dat_i = 32'h5000 + k;
            #1;
            check("rr_ack", {29'd0, m_ack}, 32'd1 << g);
            tick;
            s_ack = 1'b0;
            mset(g, 1'b0, 1'b0, 32'h0, CTI_CLASSIC);
            #1;
            check("rr_drop", {31'd0, s_cyc}, 32'd0);
            tick;
            check("rr_gap", {29'd0, grant}, 32'd0);
            if (k == 0) mset(0, 1'b1, 1'b0, 32'h1000, CTI_CLASSIC);
        end

        // burst lock: master 2 writes 8 beats while master 0 waits
        mset(2, 1'b1, 1'b1, 32'h200, CTI_INCR);
        mset(0, 1'b1, 1'b0, 32'h300, CTI_CLASSIC);
        tick;
        check("bl_grant", {29'd0, grant}, 32'd4);
        for (int b = 0; b < 8; b++) begin
            mset(2, 1'b1, 1'b1, 32'h200 + b * 4, (b == 7) ? CTI_END : CTI_INCR);
            s_ack = 1'b1;
            #1;
            check("bl_ack", {29'd0, m_ack}, 32'd4);
            check("bl_hold", {29'd0, grant}, 32'd4);
            check("bl_cti", {29'd0, s_cti}, (b == 7) ? 32'd7 : 32'd2);
            if (b == 0) begin
                check("bl_we", {31'd0, s_we}, 32'd1);
                check("bl_wdata", s_dat_o, 32'h5A5A_0200);
            end
            tick;
        end
        s_ack = 1'b0;
        mset(2, 1'b0, 1'b0, 32'h0, CTI_CLASSIC);
        #1;
        check("bl_tail", {29'd0, grant}, 32'd4);
        tick;
        check("bl_gap", {29'd0, grant}, 32'd0);
        tick;
        check("bl_next", {29'd0, grant}, 32'd1);
        s_ack = 1'b1;
        #1;
        check("bl_next_ack", {29'd0, m_ack}, 32'd1);
        tick;
        s_ack = 1'b0;
        mset(0, 1'b0, 1'b0, 32'h0, CTI_CLASSIC);
        tick;

        // watchdog: master 0 never acked, master 1 pending
        do_reset;
        mset(0, 1'b1, 1'b0, 32'h400, CTI_CLASSIC);
        mset(1, 1'b1, 1'b0, 32'h500, CTI_CLASSIC);
        tick;
        check("to_grant", {29'd0, grant}, 32'd1);
        repeat (15) tick;
        check("to_pre_cyc", {31'd0, s_cyc}, 32'd1);
        check("to_pre_err", {29'd0, m_err}, 32'd0);
        tick;
        check("to_cyc", {31'd0, s_cyc}, 32'd0);
        check("to_err", {29'd0, m_err}, 32'd1);
        tick;
        check("to_err_once", {29'd0, m_err}, 32'd0);
        check("to_flag", {31'd0, timeout}, 32'd1);
        check("to_idle", {29'd0, grant}, 32'd0);
        tick;
        check("to_regrant", {29'd0, grant}, 32'd2);
        check("to_adr", s_adr, 32'h500);
        check("to_sticky", {31'd0, timeout}, 32'd1);
        s_ack = 1'b1;
        #1;
        check("to_ack1", {29'd0, m_ack}, 32'd2);
        tick;
        s_ack = 1'b0;
        mset(0, 1'b0, 1'b0, 32'h0, CTI_CLASSIC);
        mset(1, 1'b0, 1'b0, 32'h0, CTI_CLASSIC);
        tick;
        tick;

        // reset in the middle of master 1's burst
        mset(1, 1'b1, 1'b0, 32'h600, CTI_INCR);
        tick;
        check("rb_grant", {29'd0, grant}, 32'd2);
        s_ack = 1'b1;
        repeat (3) tick;
        rst = 1'b1;
        #1;
        check("rb_cyc", {31'd0, s_cyc}, 32'd0);
        check("rb_grant0", {29'd0, grant}, 32'd0);
        check("rb_ack", {29'd0, m_ack}, 32'd0);
        check("rb_tmo_clr", {31'd0, timeout}, 32'd0);
        s_ack = 1'b0;
        tick;
        rst = 1'b0;
        mset(0, 1'b1, 1'b0, 32'h700, CTI_CLASSIC);
        tick;
        check("rb_first", {29'd0, grant}, 32'd1);
        s_ack = 1'b1;
        #1;
        check("rb_ack0", {29'd0, m_ack}, 32'd1);
        tick;
        s_ack = 1'b0;
        mset(0, 1'b0, 1'b0, 32'h0, CTI_CLASSIC);
        mset(1, 1'b0, 1'b0, 32'h0, CTI_CLASSIC);
        tick;
        tick;

        // stray ack after master 0 drops cyc
        mset(0, 1'b1, 1'b0, 32'h800, CTI_CLASSIC);
        tick;
        check("sa_grant", {29'd0, grant}, 32'd1);
        s_ack = 1'b1;
        #1;
        check("sa_ack", {29'd0, m_ack}, 32'd1);
        tick;
        mset(0, 1'b0, 1'b0, 32'h0, CTI_CLASSIC);
        #1;
        check("sa_stray_own", {29'd0, m_ack}, 32'd0);
        tick;
        check("sa_stray_idle", {29'd0, m_ack}, 32'd0);
        check("sa_idle", {29'd0, grant}, 32'd0);
        s_ack = 1'b0;
        tick;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
